// File: rtl/mlb_tile_sequencer.sv
// rtl/mlb_tile_sequencer.sv - Fill/drain sequencer for the multiple level buffer of one tile
// Writes unit tiles from the memory stream, then reads them out column by column to the PE array.
module mlb_tile_sequencer #(
  parameter int NUM_UNIT = 8,
  parameter int MAX_SUB  = 4,
  parameter int UNIT_W   = 3,
  parameter int SUB_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SUB_W:0]    num_sub,
  input  logic              abort,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic              pe_ready,
  output logic              mlb_write_en,
  output logic              mlb_read_en,
  output logic [SUB_W-1:0]  mlb_sub_tile_idx,
  output logic [UNIT_W-1:0] mlb_unit_tile_idx,
  output logic              col_valid,
  output logic [UNIT_W-1:0] col_idx,
  output logic              sub_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FLUSH} state_t;

  localparam logic [UNIT_W-1:0] UNIT_MAX  = UNIT_W'(NUM_UNIT - 1);
  localparam logic [UNIT_W-1:0] UNIT_ONE  = UNIT_W'(1);
  localparam logic [SUB_W-1:0]  SUB_ONE   = SUB_W'(1);
  localparam logic [SUB_W:0]    CNT_ONE   = (SUB_W + 1)'(1);
  localparam logic [SUB_W:0]    SUB_LIMIT = (SUB_W + 1)'(MAX_SUB);

  state_t            state, state_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [SUB_W:0]    num_sub_q, num_sub_d;
  logic              col_valid_d, sub_done_d, done_d;
  logic [UNIT_W-1:0] col_idx_d;
  logic              step, unit_last, at_last;

  assign unit_last         = (unit_q == UNIT_MAX);
  assign at_last           = unit_last && ({1'b0, sub_q} == (num_sub_q - CNT_ONE));
  assign mlb_sub_tile_idx  = sub_q;
  assign mlb_unit_tile_idx = unit_q;
  assign busy              = (state != IDLE);

  always_comb begin
    state_d      = state;
    sub_d        = sub_q;
    unit_d       = unit_q;
    num_sub_d    = num_sub_q;
    fill_ready   = 1'b0;
    mlb_write_en = 1'b0;
    mlb_read_en  = 1'b0;
    step         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          sub_d     = '0;
          unit_d    = '0;
          num_sub_d = ((num_sub == '0) || (num_sub > SUB_LIMIT)) ? SUB_LIMIT : num_sub;
        end
      end
      FILL: begin
        fill_ready   = 1'b1;
        mlb_write_en = fill_valid;
        step         = fill_valid;
        if (fill_valid && at_last) state_d = DRAIN;
      end
      DRAIN: begin
        mlb_read_en = pe_ready;
        step        = pe_ready;
        if (pe_ready && at_last) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counters return to zero after the last index so the next phase starts at entry 0.
    if (step) begin
      if (at_last) begin
        sub_d  = '0;
        unit_d = '0;
      end else begin
        unit_d = unit_q + UNIT_ONE;
        if (unit_last) sub_d = sub_q + SUB_ONE;
      end
    end

    col_valid_d = mlb_read_en;
    col_idx_d   = unit_q;
    sub_done_d  = mlb_read_en && unit_last;
    done_d      = (state == FLUSH);

    if (abort) begin
      state_d     = IDLE;
      sub_d       = '0;
      unit_d      = '0;
      num_sub_d   = '0;
      col_valid_d = 1'b0;
      col_idx_d   = '0;
      sub_done_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sub_q     <= '0;
      unit_q    <= '0;
      num_sub_q <= '0;
      col_valid <= 1'b0;
      col_idx   <= '0;
      sub_done  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      sub_q     <= sub_d;
      unit_q    <= unit_d;
      num_sub_q <= num_sub_d;
      col_valid <= col_valid_d;
      col_idx   <= col_idx_d;
      sub_done  <= sub_done_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mlb_tile_sequencer.sv
// tb/tb_mlb_tile_sequencer.sv - Self-checking bench for mlb_tile_sequencer
// A linear-position model of the tile predicts every output each cycle; directed tests pin it with literals.
module tb_mlb_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] num_sub = 3'd0;
  logic       abort = 1'b0;
  logic       fill_valid = 1'b0;
  logic       pe_ready = 1'b0;
  logic       fill_ready, mlb_write_en, mlb_read_en, col_valid, sub_done, busy, done;
  logic [1:0] mlb_sub_tile_idx;
  logic [2:0] mlb_unit_tile_idx, col_idx;

  mlb_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_sub(num_sub), .abort(abort),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .pe_ready(pe_ready),
    .mlb_write_en(mlb_write_en), .mlb_read_en(mlb_read_en),
    .mlb_sub_tile_idx(mlb_sub_tile_idx), .mlb_unit_tile_idx(mlb_unit_tile_idx),
    .col_valid(col_valid), .col_idx(col_idx), .sub_done(sub_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_FLUSH = 3;
  int ph = P_IDLE;
  int pos = 0;
  int total = 32;
  int pend = -1;
  bit done_exp = 1'b0;

  int n_wr, n_rd, n_cv, n_sd, n_done;
  int start_cyc, first_cv_cyc, last_cv_cyc, done_cyc;

  always @(negedge clk) begin
    bit exp_wr, exp_rd;
    int ns_eff;
    if (!rst) begin
      ph = P_IDLE; pos = 0; pend = -1; done_exp = 1'b0;
    end
    exp_wr = (ph == P_FILL) && fill_valid;
    exp_rd = (ph == P_DRAIN) && pe_ready;
    chk("busy", busy, ph != P_IDLE);
    chk("fill_ready", fill_ready, ph == P_FILL);
    chk("write_en", mlb_write_en, exp_wr);
    chk("read_en", mlb_read_en, exp_rd);
    chk("sub_idx", mlb_sub_tile_idx, pos / 8);
    chk("unit_idx", mlb_unit_tile_idx, pos % 8);
    chk("col_valid", col_valid, pend >= 0);
    if (pend >= 0) chk("col_idx", col_idx, pend % 8);
    chk("sub_done", sub_done, (pend >= 0) && (pend % 8 == 7));
    chk("done", done, done_exp);
    chk("rw_exclusive", mlb_read_en & mlb_write_en, 0);

    if (mlb_write_en) n_wr++;
    if (mlb_read_en) n_rd++;
    if (sub_done) n_sd++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (col_valid) begin
      n_cv++;
      last_cv_cyc = cyc;
      if (first_cv_cyc < 0) first_cv_cyc = cyc;
    end
    if (rst && start && !busy && !abort) start_cyc = cyc;

    if (rst) begin
      if (abort) begin
        ph = P_IDLE; pos = 0; pend = -1; done_exp = 1'b0;
      end else begin
        pend = exp_rd ? pos : -1;
        done_exp = (ph == P_FLUSH);
        case (ph)
          P_IDLE: if (start) begin
            ns_eff = (num_sub == 0 || num_sub > 4) ? 4 : int'(num_sub);
            total = ns_eff * 8; pos = 0; ph = P_FILL;
          end
          P_FILL: if (fill_valid) begin
            if (pos == total - 1) begin pos = 0; ph = P_DRAIN; end
            else pos++;
          end
          P_DRAIN: if (pe_ready) begin
            if (pos == total - 1) begin pos = 0; ph = P_FLUSH; end
            else pos++;
          end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_cv = 0; n_sd = 0; n_done = 0;
    start_cyc = -1; first_cv_cyc = -1; last_cv_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [2:0] ns);
    start = 1'b1;
    num_sub = ns;
    tick();
    start = 1'b0;
    num_sub = 3'($urandom_range(0, 7));
  endtask

  function automatic logic pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2 == 0);
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic int exp_total(input logic [2:0] ns);
    return (ns == 0 || ns > 4) ? 32 : int'(ns) * 8;
  endfunction

  task automatic finish_tile(input int budget, input int fv_mode, input int pr_mode,
                             input bit poke, input bit rand_abort, output bit aborted);
    bit poked = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < budget; k++) begin
      fill_valid = pick(fv_mode, k);
      pe_ready = pick(pr_mode, k);
      start = 1'b0;
      abort = 1'b0;
      if (poke && !poked && busy && !fill_ready) begin
        start = 1'b1; num_sub = 3'd1; poked = 1'b1;
      end
      if (rand_abort && $urandom_range(0, 299) == 0) begin
        abort = 1'b1; aborted = 1'b1;
      end
      tick();
      if (!busy) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (busy) begin
      errors++;
      $display("FAIL tile_timeout: busy still 1 after %0d cycles", budget);
    end
    tick();
    fill_valid = 1'b0;
    pe_ready = 1'b0;
  endtask

  task automatic run_tile(input logic [2:0] ns, input int fv_mode, input int pr_mode,
                          input bit poke, input bit rand_abort, output bit aborted);
    clear_counts();
    fill_valid = pick(fv_mode, 0);
    pe_ready = pick(pr_mode, 0);
    pulse_start(ns);
    finish_tile(2000, fv_mode, pr_mode, poke, rand_abort, aborted);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ab;
    logic [2:0] ns;
    clear_counts();
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_col_valid", col_valid, 0);
    chk("reset_col_idx", col_idx, 0);
    chk("reset_done", done, 0);
    chk("reset_idx", {mlb_sub_tile_idx, mlb_unit_tile_idx}, 0);
    rst = 1'b1;
    tick();

    // Full tile, no stalls
    run_tile(3'd4, 0, 0, 1'b0, 1'b0, ab);
    chk("t1_writes", n_wr, 32);
    chk("t1_reads", n_rd, 32);
    chk("t1_cols", n_cv, 32);
    chk("t1_sub_done", n_sd, 4);
    chk("t1_done", n_done, 1);
    chk("t1_latency", first_cv_cyc - start_cyc, 34);

    // Single sub tile
    run_tile(3'd1, 0, 0, 1'b0, 1'b0, ab);
    chk("t2_writes", n_wr, 8);
    chk("t2_reads", n_rd, 8);
    chk("t2_done", n_done, 1);
    chk("t2_done_gap", done_cyc - last_cv_cyc, 1);

    // PE backpressure toggling
    run_tile(3'd2, 0, 1, 1'b0, 1'b0, ab);
    chk("t3_reads", n_rd, 16);
    chk("t3_cols", n_cv, 16);
    chk("t3_sub_done", n_sd, 2);
    chk("t3_done", n_done, 1);

    // Fill stall at unit 3
    clear_counts();
    fill_valid = 1'b1; pe_ready = 1'b1;
    pulse_start(3'd1);
    repeat (3) tick();
    fill_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_unit", mlb_unit_tile_idx, 3);
      chk("t4_hold_sub", mlb_sub_tile_idx, 0);
      chk("t4_no_write", mlb_write_en, 0);
    end
    fill_valid = 1'b1;
    #1;
    chk("t4_resume_write", mlb_write_en, 1);
    chk("t4_resume_unit", mlb_unit_tile_idx, 3);
    finish_tile(2000, 0, 0, 1'b0, 1'b0, ab);
    chk("t4_writes", n_wr, 8);
    chk("t4_done", n_done, 1);

    // Abort at fill beat 10, then refill from index 0
    clear_counts();
    fill_valid = 1'b1;
    pulse_start(3'd4);
    repeat (10) tick();
    chk("t5_pre_abort_idx", {mlb_sub_tile_idx, mlb_unit_tile_idx}, {2'd1, 3'd2});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_idx", {mlb_sub_tile_idx, mlb_unit_tile_idx}, 0);
    repeat (2) tick();
    chk("t5_no_done", n_done, 0);
    clear_counts();
    pulse_start(3'd1);
    chk("t5_restart_write", mlb_write_en, 1);
    chk("t5_restart_idx", {mlb_sub_tile_idx, mlb_unit_tile_idx}, 0);
    finish_tile(2000, 0, 0, 1'b0, 1'b0, ab);
    chk("t5_restart_writes", n_wr, 8);
    chk("t5_restart_done", n_done, 1);

    // Asynchronous reset mid-fill
    clear_counts();
    fill_valid = 1'b1;
    pulse_start(3'd2);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("t5r_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t5r_no_done", n_done, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; num_sub = 3'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    // num_sub=0 means full tile; start during drain ignored
    run_tile(3'd0, 0, 0, 1'b1, 1'b0, ab);
    chk("t6_writes", n_wr, 32);
    chk("t6_reads", n_rd, 32);
    chk("t6_done", n_done, 1);
    tick();
    chk("t6_idle_after", busy, 0);

    // Randomized tiles
    for (int t = 0; t < 10; t++) begin
      ns = 3'($urandom_range(0, 7));
      run_tile(ns, 2, 2, 1'($urandom_range(0, 1)), 1'b1, ab);
      if (!ab) begin
        chk("rand_writes", n_wr, exp_total(ns));
        chk("rand_reads", n_rd, exp_total(ns));
        chk("rand_done", n_done, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
